// File: rtl/serial_seq_gen.sv
// Serial word transmitter: shifts a WIDTH-bit word out MSB first, then idles for GAP cycles.
// Optional sweep mode retransmits cur_value+1 back-to-back until the all-ones word has gone out.
module serial_seq_gen #(
  parameter int WIDTH = 8,
  parameter int GAP   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sweep,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     dout,
  output logic                     valid,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         cur_value,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [1:0]               dbg_state
);

  localparam int IW = $clog2(WIDTH);

  // Handshake: start is a request taken only while busy=0; a taken start
  // makes busy=1 on the next edge, and done pulses for the one cycle in which
  // busy has fallen back to 0. There is no back-pressure on dout/valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n, cur_n, next_word;
  logic [IW-1:0]    idx_n;
  logic [3:0]       gap_cnt, gap_n;
  logic             dout_n, valid_n, done_n, eow, sweep_more;

  assign next_word  = cur_value + WIDTH'(1);
  assign sweep_more = sweep && (cur_value != '1);
  assign dbg_state  = state;

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cur_n   = cur_value;
    idx_n   = bit_idx;
    gap_n   = gap_cnt;
    dout_n  = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    eow     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SHIFT;
          sh_n    = data_in;
          cur_n   = data_in;
          idx_n   = IW'(WIDTH - 1);
          dout_n  = data_in[WIDTH-1];
          valid_n = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_idx != '0) begin
          sh_n    = sh << 1;
          dout_n  = sh[WIDTH-2];
          valid_n = 1'b1;
          idx_n   = bit_idx - 1'b1;
        end else if (GAP != 0) begin
          state_n = S_GAP;
          gap_n   = 4'(GAP - 1);
        end else begin
          eow = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_n = gap_cnt - 1'b1;
        else               eow   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // End of word: either reload the incremented word straight into SHIFT or finish.
    if (eow) begin
      if (sweep_more) begin
        state_n = S_SHIFT;
        sh_n    = next_word;
        cur_n   = next_word;
        idx_n   = IW'(WIDTH - 1);
        dout_n  = next_word[WIDTH-1];
        valid_n = 1'b1;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sh        <= '0;
      cur_value <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      dout      <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cur_value <= cur_n;
      bit_idx   <= idx_n;
      gap_cnt   <= gap_n;
      dout      <= dout_n;
      valid     <= valid_n;
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
    end
  end

endmodule

// File: doc/serial_seq_gen.md
Name: serial_seq_gen

Overview:
- Serial bit-stream transmitter; the driving end of the shift_reg sequence detector's din input.
- Loads a WIDTH-bit word and shifts it out one bit per clock, MSB first, then inserts a fixed idle gap.
- An optional sweep mode auto-increments the word and retransmits, so the detector can be driven exhaustively.
- Sits between test/control logic (switches or FSM) and the detector's serial input.

Parameters:
- WIDTH, 8, word length in bits.
- GAP, 4, idle cycles after each word (dout=0, valid=0); legal range 0..15.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to transmit data_in; sampled only in IDLE.
- sweep  input  1  when 1 at end of a word's GAP, transmit cur_value+1 next.
- data_in  input  WIDTH  word to transmit, latched on accepted start.
- dout  output  1  serial data bit, registered; drives detector din.
- valid  output  1  high while dout carries a data bit.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the block returns to IDLE.
- cur_value  output  WIDTH  word currently being transmitted.
- bit_idx  output  clog2(WIDTH)  index of the bit currently on dout (WIDTH-1 down to 0).

Behaviour:
- Reset: clk and rst named as elsewhere in the codebase. Synchronous active-high: at a posedge with rst=1 the state becomes IDLE and dout, valid, busy and done all become 0. cur_value and bit_idx become 0, and the gap counter is cleared. Reset mid-word aborts the transmission immediately with no done pulse.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - busy=0, valid=0, dout=0.
  - On a posedge with start=1: latch data_in into the shift register and cur_value, set dout=data_in[WIDTH-1], valid=1, busy=1, bit_idx=WIDTH-1, go to SHIFT.
  - The first data bit is visible in the cycle after the start edge (latency 1).
- SHIFT:
  - At each posedge, shift left by one and present the next bit; bit_idx decrements.
  - After bit 0 has been held for one cycle (WIDTH valid cycles total), go to GAP with dout=0, valid=0, gap counter=GAP-1.
  - If GAP=0, skip GAP and apply the end-of-word rule directly.
- GAP:
  - Count down one per cycle; busy stays 1.
  - When the count reaches 0, apply the end-of-word rule.
- End-of-word rule:
  - If sweep=1 and cur_value is not all-ones: cur_value is incremented modulo 2^WIDTH and reloaded into the shift register, and the state returns directly to SHIFT (busy stays 1, no done pulse). This is back-to-back with no extra cycle.
  - Otherwise: go to IDLE, done=1 for exactly that cycle, busy=0 in the same cycle.
  - Sweep therefore terminates after the all-ones word.
- start while busy=1 is ignored (not queued).
- start and done may coincide. A start seen in the IDLE cycle where done=1 is accepted normally, giving back-to-back words separated only by GAP+1 idle cycles.
- data_in changes after acceptance have no effect on the word in flight.
- Sweep deasserted mid-word takes effect at that word's end.
- Total cycles per word, start edge to done: WIDTH+GAP+1.

Test Plan:
- Reset for 2 cycles, then start with data_in=8'd47. Required: dout sequence 0,0,1,0,1,1,1,1 on 8 consecutive valid cycles, then 4 cycles valid=0, then done pulses once. A connected shift_reg asserts out after the final bit.
- data_in=8'd46. Required: stream 0,0,1,0,1,1,1,0 and the detector never asserts out. Repeat for 8'd191: stream 1,0,1,1,1,1,1,1.
- Pulse start again during SHIFT with a different data_in. Required: no effect; cur_value unchanged and done after exactly 13 cycles from the original start.
- sweep=1 with start at data_in=8'd250. Required: words 250..255 sent back-to-back, each separated by 4 gap cycles, with busy continuously 1. A single done occurs after word 255.
- Assert rst during bit_idx=3 of a word. Required: next cycle dout=0, valid=0, busy=0, no done. A fresh start then transmits a correct full word.
- GAP=0 build, start with 8'hA5. Required: 8 valid cycles, then done in the following cycle. A start in that done cycle yields the next word's first bit on the next cycle.
